// File: rtl/pll_clken_gen_pkg.sv
//==============================================================================
// Module      : pll_clken_gen_pkg
// Description : Shared clocking definitions for the fractional clock-enable
//               generator: default widths, reset increment, lock filter depth
//               and a helper that converts a target rate into an increment.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package pll_clken_gen_pkg;

    localparam int                   CLK_ACC_W       = 16;
    localparam int                   CLK_LOCK_CYCLES = 1024;
    localparam logic [CLK_ACC_W-1:0] CLK_DEF_INCR    = 16'h4000;
    localparam int                   CFG_CHAN_W      = 3;

    typedef logic [CFG_CHAN_W-1:0] chan_t;

    // Increment giving f_out = f_ref * incr / 2^acc_w, rounded to nearest.
    function automatic longint unsigned incr_for(
        input longint unsigned f_out_hz,
        input longint unsigned f_ref_hz,
        input int              acc_w
    );
        longint unsigned scaled;
        scaled = (f_out_hz << acc_w) + (f_ref_hz >> 1);
        return scaled / f_ref_hz;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pll_clken_gen_if.sv
//==============================================================================
// Module      : pll_clken_gen_if
// Description : Valid/ready configuration bus carrying a channel index and a
//               new phase increment into the clock-enable generator.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface pll_clken_gen_if
    import pll_clken_gen_pkg::*;
#(
    parameter int ACC_W = CLK_ACC_W
) ();

    logic             cfg_valid;
    logic             cfg_ready;
    chan_t            cfg_chan;
    logic [ACC_W-1:0] cfg_incr;

    modport master (
        output cfg_valid,
        output cfg_chan,
        output cfg_incr,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_chan,
        input  cfg_incr,
        output cfg_ready
    );

endinterface

`default_nettype wire

// File: rtl/pll_nco_chan.sv
//==============================================================================
// Module      : pll_nco_chan
// Description : One phase-accumulator channel. The accumulator carry is
//               registered as the enable strobe; the increment register is
//               replaced only when the top level asserts apply, which it does
//               at a carry boundary so periods are never shortened.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pll_nco_chan
    import pll_clken_gen_pkg::*;
#(
    parameter int               ACC_W    = CLK_ACC_W,
    parameter logic [ACC_W-1:0] DEF_INCR = ACC_W'(CLK_DEF_INCR)
) (
    input  wire logic             refclk,
    input  wire logic             rst,
    input  wire logic             run,
    input  wire logic             sync,
    input  wire logic             apply,
    input  wire logic [ACC_W-1:0] new_incr,
    output logic                  carry,
    output logic                  incr_zero,
    output logic                  ce
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_incr;
    logic             r_ce;
    logic [ACC_W:0]   w_sum;

    // Next phase with the carry kept as the extra top bit.
    always_comb begin
        w_sum = {1'b0, r_acc} + {1'b0, r_incr};
    end

    assign carry     = w_sum[ACC_W];
    assign incr_zero = (r_incr == '0);
    assign ce        = r_ce;

    // Accumulator and strobe; idle or sync forces phase zero and no strobe.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_acc <= '0;
            r_ce  <= 1'b0;
        end else if (!run || sync) begin
            r_acc <= '0;
            r_ce  <= 1'b0;
        end else begin
            r_acc <= w_sum[ACC_W-1:0];
            r_ce  <= w_sum[ACC_W];
        end
    end

    // Increment register; the carry of the apply cycle still used the old value.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_incr <= DEF_INCR;
        end else if (apply) begin
            r_incr <= new_incr;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pll_clken_gen.sv
//==============================================================================
// Module      : pll_clken_gen
// Description : Multi-channel fractional clock-enable generator. Holds the PLL
//               lock filter and a single pending configuration slot, and
//               instantiates one phase-accumulator channel per enable output.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module pll_clken_gen
    import pll_clken_gen_pkg::*;
#(
    parameter int               NUM_CH      = 3,
    parameter int               ACC_W       = CLK_ACC_W,
    parameter int               LOCK_CYCLES = CLK_LOCK_CYCLES,
    parameter logic [ACC_W-1:0] DEF_INCR    = ACC_W'(CLK_DEF_INCR)
) (
    input  wire logic          refclk,
    input  wire logic          rst,
    input  wire logic          locked_in,
    input  wire logic          sync_in,
    pll_clken_gen_if.slave     cfg,
    output logic [NUM_CH-1:0]  ce,
    output logic               locked
);

    localparam int               CNT_W   = $clog2(LOCK_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_CYCLES);

    logic [CNT_W-1:0]  r_lock_cnt;
    logic              r_locked;
    logic              r_pend;
    chan_t             r_pend_chan;
    logic [ACC_W-1:0]  r_pend_incr;
    logic              r_ready;

    logic              w_run;
    logic              w_xfer;
    logic              w_pend_done;
    logic [NUM_CH-1:0] w_carry;
    logic [NUM_CH-1:0] w_incr_zero;
    logic [NUM_CH-1:0] w_hit;
    logic [NUM_CH-1:0] w_apply;
    logic [NUM_CH-1:0] w_ce;

    // A raw lock drop stops the channels on the same edge that clears locked.
    assign w_run  = r_locked & locked_in;
    assign w_xfer = cfg.cfg_valid & r_ready;

    // An out-of-range channel never hits, so its update is simply dropped.
    assign w_pend_done = r_pend & (~(|w_hit) | (|w_apply));

    assign cfg.cfg_ready = r_ready;
    assign ce            = w_ce;
    assign locked        = r_locked;

    // Lock filter: count consecutive locked_in cycles, saturate, clear on any drop.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else if (!locked_in) begin
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
        end else begin
            if (r_lock_cnt != CNT_MAX) begin
                r_lock_cnt <= r_lock_cnt + CNT_W'(1);
            end
            r_locked <= (r_lock_cnt == CNT_MAX);
        end
    end

    // Single pending slot: accept one update, hold off the master until it lands.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_pend      <= 1'b0;
            r_pend_chan <= '0;
            r_pend_incr <= '0;
            r_ready     <= 1'b0;
        end else if (w_xfer) begin
            r_pend      <= 1'b1;
            r_pend_chan <= cfg.cfg_chan;
            r_pend_incr <= cfg.cfg_incr;
            r_ready     <= 1'b0;
        end else if (w_pend_done) begin
            r_pend  <= 1'b0;
            r_ready <= 1'b1;
        end else if (!r_pend) begin
            r_ready <= 1'b1;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        assign w_hit[ch]   = r_pend & (r_pend_chan == CFG_CHAN_W'(ch));
        // Swap increments only where the phase wraps or the channel is frozen.
        assign w_apply[ch] = w_hit[ch]
                           & (w_carry[ch] | sync_in | ~w_run | w_incr_zero[ch]);

        pll_nco_chan #(
            .ACC_W    (ACC_W),
            .DEF_INCR (DEF_INCR)
        ) u_nco (
            .refclk    (refclk),
            .rst       (rst),
            .run       (w_run),
            .sync      (sync_in),
            .apply     (w_apply[ch]),
            .new_incr  (r_pend_incr),
            .carry     (w_carry[ch]),
            .incr_zero (w_incr_zero[ch]),
            .ce        (w_ce[ch])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_pll_clken_gen.sv
//==============================================================================
// Module      : tb_pll_clken_gen
// Description : Self-checking bench for pll_clken_gen with a cycle-level
//               reference model derived from the rate/lock/handshake rules.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_pll_clken_gen;
    import pll_clken_gen_pkg::*;

    localparam int NCH = 3;
    localparam int LC  = 8;
    localparam int MOD = 1 << 16;

    logic           refclk    = 1'b0;
    logic           rst       = 1'b1;
    logic           locked_in = 1'b0;
    logic           sync_in   = 1'b0;
    logic [NCH-1:0] ce;
    logic           locked;

    int n_checks = 0;
    int n_errors = 0;

    pll_clken_gen_if #(.ACC_W(16)) cfg_if ();

    pll_clken_gen #(
        .NUM_CH      (NCH),
        .ACC_W       (16),
        .LOCK_CYCLES (LC),
        .DEF_INCR    (16'h4000)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .locked_in (locked_in),
        .sync_in   (sync_in),
        .cfg       (cfg_if),
        .ce        (ce),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    // Reference model state
    int m_cnt = 0;
    bit m_locked = 1'b0;
    int m_acc [NCH] = '{default: 0};
    bit m_ce  [NCH] = '{default: 1'b0};
    int m_incr[NCH] = '{default: 'h4000};
    bit m_pend = 1'b0;
    int m_pchan = 0;
    int m_pincr = 0;
    bit m_ready = 1'b0;

    function automatic logic [NCH-1:0] model_ce();
        logic [NCH-1:0] v;
        for (int c = 0; c < NCH; c++) v[c] = m_ce[c];
        return v;
    endfunction

    // Advance one clock; model computes the next state from rules on current inputs.
    task automatic step();
        int n_acc[NCH]; bit n_ce[NCH]; int n_incr[NCH]; bit carry[NCH];
        int n_cnt, n_pchan, n_pincr, s;
        bit n_locked, n_pend, n_ready, run, done;
        n_cnt = m_cnt; n_locked = m_locked; n_pend = m_pend; n_ready = m_ready;
        n_pchan = m_pchan; n_pincr = m_pincr; done = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            n_acc[c] = m_acc[c]; n_ce[c] = m_ce[c]; n_incr[c] = m_incr[c];
        end
        if (rst) begin
            n_cnt = 0; n_locked = 0; n_pend = 0; n_ready = 0;
            for (int c = 0; c < NCH; c++) begin
                n_acc[c] = 0; n_ce[c] = 0; n_incr[c] = 'h4000;
            end
        end else begin
            run = m_locked && locked_in;
            for (int c = 0; c < NCH; c++) begin
                s = m_acc[c] + m_incr[c];
                carry[c] = (s >= MOD);
                if (!run || sync_in) begin
                    n_acc[c] = 0; n_ce[c] = 0;
                end else begin
                    n_acc[c] = s % MOD; n_ce[c] = carry[c];
                end
            end
            if (m_pend) begin
                if (m_pchan >= NCH) done = 1'b1;
                else if (carry[m_pchan] || sync_in || !run || m_incr[m_pchan] == 0) begin
                    n_incr[m_pchan] = m_pincr;
                    done = 1'b1;
                end
            end
            if (!locked_in) begin
                n_cnt = 0; n_locked = 0;
            end else begin
                n_locked = (m_cnt == LC);
                n_cnt = (m_cnt < LC) ? m_cnt + 1 : LC;
            end
            if (cfg_if.cfg_valid && m_ready) begin
                n_pend = 1; n_pchan = int'(cfg_if.cfg_chan); n_pincr = int'(cfg_if.cfg_incr); n_ready = 0;
            end else if (done) begin
                n_pend = 0; n_ready = 1;
            end else if (!m_pend) begin
                n_ready = 1;
            end
        end
        @(posedge refclk);
        m_cnt = n_cnt; m_locked = n_locked; m_pend = n_pend; m_ready = n_ready;
        m_pchan = n_pchan; m_pincr = n_pincr;
        for (int c = 0; c < NCH; c++) begin
            m_acc[c] = n_acc[c]; m_ce[c] = n_ce[c]; m_incr[c] = n_incr[c];
        end
        #1;
    endtask

    // Drive one config write and hold it until the block takes it (bounded).
    task automatic cfg_write(input int ch, input int inc);
        bit taken = 1'b0;
        bit was;
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_chan  = 3'(ch);
        cfg_if.cfg_incr  = 16'(inc);
        for (int k = 0; k < 64 && !taken; k++) begin
            was = cfg_if.cfg_ready;
            step();
            taken = was;
        end
        cfg_if.cfg_valid = 1'b0;
        n_checks++;
        if (!taken) begin
            n_errors++;
            $display("FAIL cfg_write_timeout ch%0d: cfg_ready=%0b, required 1 within 64 cycles", ch, cfg_if.cfg_ready);
        end
    endtask

    // Step until the given channel strobes (bounded).
    task automatic wait_ce(input int b);
        bit seen = 1'b0;
        for (int k = 0; k < 64 && !seen; k++) begin
            step();
            seen = ce[b];
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL wait_ce%0d_timeout: ce=%b, required a strobe within 64 cycles", b, ce);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        n_checks++; if (ce !== '0)              begin n_errors++; $display("FAIL reset_ce: got %b expected 000", ce); end
        n_checks++; if (locked !== 1'b0)        begin n_errors++; $display("FAIL reset_locked: got %b expected 0", locked); end
        n_checks++; if (cfg_if.cfg_ready !== 0) begin n_errors++; $display("FAIL reset_ready: got %b expected 0", cfg_if.cfg_ready); end
        rst = 1'b0;
        step();
        n_checks++; if (cfg_if.cfg_ready !== 1) begin n_errors++; $display("FAIL ready_after_rst: got %b expected 1", cfg_if.cfg_ready); end
    endtask

    task automatic test_lock_filter();
        locked_in = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            step();
            n_checks++;
            if (locked !== (i >= 9)) begin n_errors++; $display("FAIL lock_count cycle %0d: got %b expected %b", i, locked, (i >= 9)); end
            n_checks++;
            if (i < 9 && ce !== '0) begin n_errors++; $display("FAIL ce_while_unlocked cycle %0d: got %b expected 000", i, ce); end
        end
        locked_in = 1'b0;
        step();
        n_checks++; if (locked !== 1'b0) begin n_errors++; $display("FAIL lock_drop: got %b expected 0", locked); end
        for (int i = 1; i <= 14; i++) begin
            locked_in = (i != 5);
            step();
            n_checks++;
            if (locked !== (i == 14)) begin n_errors++; $display("FAIL lock_restart cycle %0d: got %b expected %b", i, locked, (i == 14)); end
        end
        locked_in = 1'b1;
    endtask

    task automatic test_default_rate();
        logic [NCH-1:0] exp;
        int cnt2 = 0;
        for (int i = 1; i <= 16; i++) begin
            step();
            exp = (i % 4 == 0) ? '1 : '0;
            n_checks++;
            if (ce !== exp) begin n_errors++; $display("FAIL default_rate cycle %0d: got %b expected %b", i, ce, exp); end
        end
        cfg_write(2, int'(incr_for(3, 8, 16)));
        for (int i = 0; i < 8; i++) step();
        for (int i = 0; i < 16; i++) begin
            step();
            cnt2 += int'(ce[2]);
            n_checks++;
            if (ce !== model_ce()) begin n_errors++; $display("FAIL rate_6000_model: got %b expected %b", ce, model_ce()); end
        end
        n_checks++;
        if (cnt2 != 6) begin n_errors++; $display("FAIL rate_6000_count: got %0d pulses in 16 cycles expected 6", cnt2); end
    endtask

    task automatic test_cfg_mid_period();
        bit seen = 1'b0;
        int last = 0, npulse = 0;
        wait_ce(1);
        step();
        cfg_write(1, 'h8000);
        n_checks++; if (cfg_if.cfg_ready !== 0) begin n_errors++; $display("FAIL mid_ready_after_xfer: got %b expected 0", cfg_if.cfg_ready); end
        for (int k = 0; k < 8 && !seen; k++) begin
            step();
            seen = ce[1];
            n_checks++;
            if (cfg_if.cfg_ready !== seen) begin n_errors++; $display("FAIL mid_ready_vs_strobe: got %b expected %b", cfg_if.cfg_ready, seen); end
        end
        n_checks++; if (!seen) begin n_errors++; $display("FAIL mid_no_strobe: got 0 expected ch1 strobe"); end
        for (int i = 1; i <= 12; i++) begin
            step();
            if (ce[1]) begin
                npulse++;
                n_checks++;
                if (i - last != 2) begin n_errors++; $display("FAIL ch1_period: got %0d expected 2", i - last); end
                last = i;
            end
        end
        n_checks++; if (npulse != 6) begin n_errors++; $display("FAIL ch1_pulses: got %0d expected 6", npulse); end
    endtask

    task automatic test_sync();
        logic [NCH-1:0] exp;
        cfg_write(1, 'h4000);
        cfg_write(2, 'h4000);
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) step();
        sync_in = 1'b1;
        step();
        sync_in = 1'b0;
        n_checks++; if (ce !== '0) begin n_errors++; $display("FAIL sync_ce_clear: got %b expected 000", ce); end
        for (int i = 1; i <= 4; i++) begin
            step();
            exp = (i == 4) ? '1 : '0;
            n_checks++;
            if (ce !== exp) begin n_errors++; $display("FAIL sync_align cycle %0d: got %b expected %b", i, ce, exp); end
        end
    endtask

    task automatic test_lock_loss();
        int c0 = 0, c1 = 0;
        wait_ce(0);
        cfg_write(0, 'h1000);
        n_checks++; if (cfg_if.cfg_ready !== 0) begin n_errors++; $display("FAIL loss_pending_ready: got %b expected 0", cfg_if.cfg_ready); end
        locked_in = 1'b0;
        step();
        n_checks++; if (locked !== 0)           begin n_errors++; $display("FAIL loss_locked: got %b expected 0", locked); end
        n_checks++; if (ce !== '0)              begin n_errors++; $display("FAIL loss_ce: got %b expected 000", ce); end
        n_checks++; if (cfg_if.cfg_ready !== 1) begin n_errors++; $display("FAIL loss_ready: got %b expected 1", cfg_if.cfg_ready); end
        locked_in = 1'b1;
        for (int i = 1; i <= 9; i++) step();
        n_checks++; if (locked !== 1) begin n_errors++; $display("FAIL relock: got %b expected 1", locked); end
        for (int i = 0; i < 32; i++) begin
            step();
            c0 += int'(ce[0]);
            c1 += int'(ce[1]);
        end
        n_checks++; if (c0 != 2) begin n_errors++; $display("FAIL loss_applied_ch0: got %0d pulses expected 2", c0); end
        n_checks++; if (c1 != 8) begin n_errors++; $display("FAIL loss_ch1_rate: got %0d pulses expected 8", c1); end
    endtask

    task automatic test_reset_mid_run();
        logic [NCH-1:0] exp;
        bit got_lock = 1'b0;
        wait_ce(1);
        cfg_write(1, 'h1000);
        rst = 1'b1;
        step();
        n_checks++; if (ce !== '0)              begin n_errors++; $display("FAIL rstmid_ce: got %b expected 000", ce); end
        n_checks++; if (locked !== 0)           begin n_errors++; $display("FAIL rstmid_locked: got %b expected 0", locked); end
        n_checks++; if (cfg_if.cfg_ready !== 0) begin n_errors++; $display("FAIL rstmid_ready: got %b expected 0", cfg_if.cfg_ready); end
        rst = 1'b0;
        step();
        n_checks++; if (cfg_if.cfg_ready !== 1) begin n_errors++; $display("FAIL rstmid_ready_up: got %b expected 1", cfg_if.cfg_ready); end
        cfg_write(5, 'h1234);
        n_checks++; if (cfg_if.cfg_ready !== 0) begin n_errors++; $display("FAIL chan5_accept: got %b expected 0", cfg_if.cfg_ready); end
        step();
        n_checks++; if (cfg_if.cfg_ready !== 1) begin n_errors++; $display("FAIL chan5_discard: got %b expected 1", cfg_if.cfg_ready); end
        for (int k = 0; k < 20 && !got_lock; k++) begin
            step();
            got_lock = locked;
        end
        n_checks++; if (!got_lock) begin n_errors++; $display("FAIL rstmid_relock: got 0 expected 1 within 20 cycles"); end
        for (int i = 1; i <= 16; i++) begin
            step();
            exp = (i % 4 == 0) ? '1 : '0;
            n_checks++;
            if (ce !== exp) begin n_errors++; $display("FAIL rstmid_def_incr cycle %0d: got %b expected %b", i, ce, exp); end
        end
    endtask

    task automatic test_random();
        bit was;
        int sel;
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            locked_in = ($urandom_range(0, 24) != 0);
            sync_in   = ($urandom_range(0, 29) == 0);
            if (!cfg_if.cfg_valid && $urandom_range(0, 3) == 0) begin
                cfg_if.cfg_valid = 1'b1;
                cfg_if.cfg_chan  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                sel = int'($urandom_range(0, 3));
                case (sel)
                    0:       cfg_if.cfg_incr = 16'h0000;
                    1:       cfg_if.cfg_incr = 16'h8000;
                    2:       cfg_if.cfg_incr = 16'h4000;
                    default: cfg_if.cfg_incr = 16'($urandom);
                endcase
            end
            was = cfg_if.cfg_ready;
            step();
            if (was) cfg_if.cfg_valid = 1'b0;
            n_checks++; if (ce !== model_ce())          begin n_errors++; $display("FAIL rand_ce cycle %0d: got %b expected %b", i, ce, model_ce()); end
            n_checks++; if (locked !== m_locked)        begin n_errors++; $display("FAIL rand_locked cycle %0d: got %b expected %b", i, locked, m_locked); end
            n_checks++; if (cfg_if.cfg_ready !== m_ready) begin n_errors++; $display("FAIL rand_ready cycle %0d: got %b expected %b", i, cfg_if.cfg_ready, m_ready); end
        end
        rst = 1'b0; sync_in = 1'b0; cfg_if.cfg_valid = 1'b0;
    endtask

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_chan  = '0;
        cfg_if.cfg_incr  = '0;
        test_reset();
        test_lock_filter();
        test_default_rate();
        test_cfg_mid_period();
        test_sync();
        test_lock_loss();
        test_reset_mid_run();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
